// File: rtl/splitting_4kb_resp_merger.sv
// Rejoins B and R responses of AXI bursts split at a 4KB boundary into one master transaction.
// Optional macro SPLIT_MERGER_R_ERR_STICKY_EN: worst RESP of a split read carries forward to later beats.
module splitting_4kb_resp_merger #(
  parameter int DATA_WIDTH  = 32,
  parameter int RESP_WIDTH  = 2,
  parameter int OUTST_DEPTH = 4
) (
  input  logic                  ACLK_i,
  input  logic                  ARESETn_i,
  input  logic                  aw_push_i,
  input  logic                  aw_cross_i,
  output logic                  aw_info_full_o,
  input  logic                  ar_push_i,
  input  logic                  ar_cross_i,
  output logic                  ar_info_full_o,
  input  logic [RESP_WIDTH-1:0] sB_resp_i,
  input  logic                  sB_valid_i,
  output logic                  sB_ready_o,
  output logic [RESP_WIDTH-1:0] mB_resp_o,
  output logic                  mB_valid_o,
  input  logic                  mB_ready_i,
  input  logic [DATA_WIDTH-1:0] sR_data_i,
  input  logic [RESP_WIDTH-1:0] sR_resp_i,
  input  logic                  sR_last_i,
  input  logic                  sR_valid_i,
  output logic                  sR_ready_o,
  output logic [DATA_WIDTH-1:0] mR_data_o,
  output logic [RESP_WIDTH-1:0] mR_resp_o,
  output logic                  mR_last_o,
  output logic                  mR_valid_o,
  input  logic                  mR_ready_i
);
  localparam int PW = $clog2(OUTST_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(OUTST_DEPTH);

  typedef enum logic {B_FIRST, B_SECOND} b_state_t;
  typedef enum logic {R_FIRST, R_SECOND} r_state_t;

  logic [OUTST_DEPTH-1:0] w_mem, r_mem;
  logic [PW:0]            w_wr, w_rd, r_wr, r_rd;
  logic                   w_full, w_empty, w_head, w_push, w_pop;
  logic                   r_full, r_empty, r_head, r_push, r_pop;

  assign w_full         = ((w_wr - w_rd) == DEPTH_CNT);
  assign w_empty        = (w_wr == w_rd);
  assign w_head         = w_mem[w_rd[PW-1:0]];
  assign w_push         = aw_push_i && !w_full;
  assign r_full         = ((r_wr - r_rd) == DEPTH_CNT);
  assign r_empty        = (r_wr == r_rd);
  assign r_head         = r_mem[r_rd[PW-1:0]];
  assign r_push         = ar_push_i && !r_full;
  assign aw_info_full_o = w_full;
  assign ar_info_full_o = r_full;

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      w_mem <= '0;
      w_wr  <= '0;
      w_rd  <= '0;
      r_mem <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
    end else begin
      if (w_push) begin
        w_mem[w_wr[PW-1:0]] <= aw_cross_i;
        w_wr                <= w_wr + 1'b1;
      end
      if (w_pop) w_rd <= w_rd + 1'b1;
      if (r_push) begin
        r_mem[r_wr[PW-1:0]] <= ar_cross_i;
        r_wr                <= r_wr + 1'b1;
      end
      if (r_pop) r_rd <= r_rd + 1'b1;
    end
  end

  // Write response path
  b_state_t              b_state, b_next;
  logic [RESP_WIDTH-1:0] b_acc, b_load_resp;
  logic                  b_absorb, b_hs, b_load;

  always_comb begin
    b_next      = b_state;
    b_load      = 1'b0;
    w_pop       = 1'b0;
    b_absorb    = (b_state == B_FIRST) && w_head;
    sB_ready_o  = !w_empty && (b_absorb || !mB_valid_o || mB_ready_i);
    b_hs        = sB_valid_i && sB_ready_o;
    b_load_resp = sB_resp_i;
    if (b_state == B_SECOND && b_acc > sB_resp_i) b_load_resp = b_acc;
    if (b_hs) begin
      if (b_state == B_SECOND) begin
        b_load = 1'b1;
        w_pop  = 1'b1;
        b_next = B_FIRST;
      end else if (w_head) begin
        b_next = B_SECOND;
      end else begin
        b_load = 1'b1;
        w_pop  = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      b_state    <= B_FIRST;
      b_acc      <= '0;
      mB_resp_o  <= '0;
      mB_valid_o <= 1'b0;
    end else begin
      b_state <= b_next;
      if (b_hs && b_absorb) b_acc <= sB_resp_i;
      if (b_load) begin
        mB_resp_o  <= b_load_resp;
        mB_valid_o <= 1'b1;
      end else if (mB_ready_i) begin
        mB_valid_o <= 1'b0;
      end
    end
  end

  // Read response path
  r_state_t              r_state, r_next;
  logic [RESP_WIDTH-1:0] r_resp_out;
  logic                  r_split_first, r_hs;

  always_comb begin
    r_next        = r_state;
    r_pop         = 1'b0;
    r_split_first = (r_state == R_FIRST) && r_head;
    sR_ready_o    = !r_empty && (!mR_valid_o || mR_ready_i);
    r_hs          = sR_valid_i && sR_ready_o;
    if (r_hs && sR_last_i) begin
      if (r_split_first) begin
        r_next = R_SECOND;
      end else begin
        r_pop  = 1'b1;
        r_next = R_FIRST;
      end
    end
  end

`ifdef SPLIT_MERGER_R_ERR_STICKY_EN
  logic [RESP_WIDTH-1:0] r_err_acc;

  assign r_resp_out = (r_err_acc > sR_resp_i) ? r_err_acc : sR_resp_i;

  // Only split reads accumulate, so a plain burst never inherits an older error.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_err_acc <= '0;
    end else if (r_hs) begin
      if (r_pop) r_err_acc <= '0;
      else if (r_split_first || r_state == R_SECOND) r_err_acc <= r_resp_out;
    end
  end
`else
  assign r_resp_out = sR_resp_i;
`endif

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_state    <= R_FIRST;
      mR_data_o  <= '0;
      mR_resp_o  <= '0;
      mR_last_o  <= 1'b0;
      mR_valid_o <= 1'b0;
    end else begin
      r_state <= r_next;
      if (r_hs) begin
        mR_data_o  <= sR_data_i;
        mR_resp_o  <= r_resp_out;
        mR_last_o  <= sR_last_i && !r_split_first;
        mR_valid_o <= 1'b1;
      end else if (mR_ready_i) begin
        mR_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_splitting_4kb_resp_merger.sv
// Directed bench for splitting_4kb_resp_merger: B merging, R last suppression, full flag, reset.
module tb_splitting_4kb_resp_merger;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        aw_push, aw_cross, aw_full;
  logic        ar_push, ar_cross, ar_full;
  logic [1:0]  sB_resp, mB_resp;
  logic        sB_valid, sB_ready, mB_valid, mB_ready;
  logic [31:0] sR_data, mR_data;
  logic [1:0]  sR_resp, mR_resp;
  logic        sR_last, sR_valid, sR_ready, mR_last, mR_valid, mR_ready;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [1:0]  exp_resp [5];

  always #5 clk = ~clk;

  splitting_4kb_resp_merger #(.DATA_WIDTH(32), .RESP_WIDTH(2), .OUTST_DEPTH(4)) dut (
    .ACLK_i(clk), .ARESETn_i(rst_n),
    .aw_push_i(aw_push), .aw_cross_i(aw_cross), .aw_info_full_o(aw_full),
    .ar_push_i(ar_push), .ar_cross_i(ar_cross), .ar_info_full_o(ar_full),
    .sB_resp_i(sB_resp), .sB_valid_i(sB_valid), .sB_ready_o(sB_ready),
    .mB_resp_o(mB_resp), .mB_valid_o(mB_valid), .mB_ready_i(mB_ready),
    .sR_data_i(sR_data), .sR_resp_i(sR_resp), .sR_last_i(sR_last), .sR_valid_i(sR_valid),
    .sR_ready_o(sR_ready),
    .mR_data_o(mR_data), .mR_resp_o(mR_resp), .mR_last_o(mR_last), .mR_valid_o(mR_valid),
    .mR_ready_i(mR_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_beat(input logic [1:0] r);
    sB_valid = 1'b1;
    sB_resp  = r;
    #1;
    for (int i = 0; i < 20 && !sB_ready; i++) tick();
    if (!sB_ready) chk("b_ready_timeout", 32'd0, 32'd1);
    tick();
    sB_valid = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] d, input logic [1:0] r, input logic l);
    sR_valid = 1'b1;
    sR_data  = d;
    sR_resp  = r;
    sR_last  = l;
    #1;
    for (int i = 0; i < 20 && !sR_ready; i++) tick();
    if (!sR_ready) chk("r_ready_timeout", 32'd0, 32'd1);
    tick();
    sR_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    aw_push = 0; aw_cross = 0; ar_push = 0; ar_cross = 0;
    sB_resp = 0; sB_valid = 0; mB_ready = 0;
    sR_data = 0; sR_resp = 0; sR_last = 0; sR_valid = 0; mR_ready = 0;
    tick(); tick();
    chk("rst_mB_valid", mB_valid, 0);
    chk("rst_mR_valid", mR_valid, 0);
    chk("rst_mR_last", mR_last, 0);
    chk("rst_mR_data", mR_data, 0);
    chk("rst_aw_full", aw_full, 0);
    chk("rst_ar_full", ar_full, 0);
    chk("rst_sB_ready", sB_ready, 0);
    chk("rst_sR_ready", sR_ready, 0);
    rst_n = 1'b1;
    tick();

    // Non-split write
    aw_push = 1; aw_cross = 0; tick(); aw_push = 0;
    b_beat(2'd1);
    chk("ns_mB_valid", mB_valid, 1);
    chk("ns_mB_resp", mB_resp, 1);
    mB_ready = 1; tick();
    chk("ns_mB_clear", mB_valid, 0);
    chk("ns_fifo_empty", sB_ready, 0);
    mB_ready = 0;

    // Split write
    aw_push = 1; aw_cross = 1; tick(); aw_push = 0;
    b_beat(2'd0);
    chk("sw_no_first", mB_valid, 0);
    b_beat(2'd2);
    chk("sw_mB_valid", mB_valid, 1);
    chk("sw_mB_resp", mB_resp, 2);
    tick();
    chk("sw_hold_valid", mB_valid, 1);
    chk("sw_hold_resp", mB_resp, 2);
    mB_ready = 1; tick();
    chk("sw_mB_clear", mB_valid, 0);
    mB_ready = 0;

    // Split read 3+2 beats with a 3-cycle master stall
    ar_push = 1; ar_cross = 1; tick(); ar_push = 0;
    mR_ready = 1;
    r_beat(32'd1, 2'd0, 1'b0);
    chk("sr1_data", mR_data, 1); chk("sr1_last", mR_last, 0);
    r_beat(32'd2, 2'd0, 1'b0);
    chk("sr2_data", mR_data, 2);
    r_beat(32'd3, 2'd0, 1'b1);
    chk("sr3_data", mR_data, 3); chk("sr3_last_suppressed", mR_last, 0);
    mR_ready = 0;
    sR_valid = 1; sR_data = 32'd4; sR_last = 0; sR_resp = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data", mR_data, 3);
      chk("stall_valid", mR_valid, 1);
      chk("stall_sR_ready", sR_ready, 0);
    end
    mR_ready = 1; #1;
    chk("unstall_sR_ready", sR_ready, 1);
    tick(); sR_valid = 0;
    chk("sr4_data", mR_data, 4); chk("sr4_last", mR_last, 0);
    r_beat(32'd5, 2'd0, 1'b1);
    chk("sr5_data", mR_data, 5); chk("sr5_last", mR_last, 1);
    tick();
    chk("sr_drained", mR_valid, 0);
    chk("sr_fifo_empty", sR_ready, 0);

    // Error RESP on beat 2 of a split read
`ifdef SPLIT_MERGER_R_ERR_STICKY_EN
    exp_resp = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd3};
`else
    exp_resp = '{2'd0, 2'd3, 2'd0, 2'd0, 2'd0};
`endif
    ar_push = 1; ar_cross = 1; tick(); ar_cross = 0; tick(); ar_push = 0;
    r_beat(32'h11, 2'd0, 1'b0); chk("er1_resp", mR_resp, exp_resp[0]);
    r_beat(32'h12, 2'd3, 1'b0); chk("er2_resp", mR_resp, exp_resp[1]);
    r_beat(32'h13, 2'd0, 1'b1); chk("er3_resp", mR_resp, exp_resp[2]);
    r_beat(32'h14, 2'd0, 1'b0); chk("er4_resp", mR_resp, exp_resp[3]);
    r_beat(32'h15, 2'd0, 1'b1); chk("er5_resp", mR_resp, exp_resp[4]);
    chk("er5_last", mR_last, 1);
    r_beat(32'h21, 2'd0, 1'b1);
    chk("er_next_resp", mR_resp, 0); chk("er_next_last", mR_last, 1);
    tick();
    chk("er_fifo_empty", sR_ready, 0);
    mR_ready = 0;

    // Back-to-back: fill write FIFO, extra push dropped, drain in order
    aw_push = 1;
    aw_cross = 0; tick();
    aw_cross = 1; tick();
    aw_cross = 0; tick();
    aw_cross = 1; tick();
    chk("bb_full", aw_full, 1);
    aw_cross = 0; tick(); aw_push = 0;
    chk("bb_full_after_drop", aw_full, 1);
    mB_ready = 1;
    b_beat(2'd1); chk("bb0_valid", mB_valid, 1); chk("bb0_resp", mB_resp, 1);
    chk("bb_not_full", aw_full, 0);
    b_beat(2'd2); chk("bb1a_none", mB_valid, 0);
    b_beat(2'd0); chk("bb1_valid", mB_valid, 1); chk("bb1_resp", mB_resp, 2);
    b_beat(2'd3); chk("bb2_valid", mB_valid, 1); chk("bb2_resp", mB_resp, 3);
    b_beat(2'd0); chk("bb3a_none", mB_valid, 0);
    b_beat(2'd1); chk("bb3_valid", mB_valid, 1); chk("bb3_resp", mB_resp, 1);
    tick();
    chk("bb_drained", mB_valid, 0);
    chk("bb_dropped", sB_ready, 0);
    mB_ready = 0;

    // Reset while waiting for the second half of a split write
    aw_push = 1; aw_cross = 1; tick(); aw_push = 0;
    b_beat(2'd2);
    chk("rs_in_second", mB_valid, 0);
    #2 rst_n = 1'b0; #1;
    chk("rs_mB_valid", mB_valid, 0);
    chk("rs_mB_resp", mB_resp, 0);
    chk("rs_sB_ready", sB_ready, 0);
    chk("rs_aw_full", aw_full, 0);
    tick(); rst_n = 1'b1; tick();
    aw_push = 1; aw_cross = 0; tick(); aw_push = 0;
    b_beat(2'd1);
    chk("rs_after_valid", mB_valid, 1);
    chk("rs_after_resp", mB_resp, 1);
    mB_ready = 1; tick();
    chk("rs_after_clear", mB_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
